// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment display blocks.
// Glyphs are active-low {a,b,c,d,e,f,g,dp} with the dp bit left dark.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry n is the glyph for nibble n (0..9, A, b, C, d, E, F).
  localparam logic [15:0][7:0] GLYPHS = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

  function automatic int idx_width(input int digits);
    return (digits <= 2) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-segment decoder with hex/decimal mode, blanking
// and an independent decimal point; all outputs active-low.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
    seg = GLYPHS[nibble];
    if (blank || (!hex_mode && (nibble > 4'd9))) begin
      seg = SEG_BLANK;
    end
    seg[0] = ~dp;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: scan timing, guard
// band, double-buffered digit data and leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SLOT_CYC  = 50000,
  parameter int GUARD_CYC = 2,
  parameter int HEX_MODE  = 1,
  parameter int LZ_BLANK  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int IW = idx_width(DIGITS);
  localparam int CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] GUARD     = CW'(GUARD_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0] slot_cnt;
  logic [IW-1:0] idx;
  logic          slot_end;
  logic          wrap;
  logic          in_guard;

  logic [DIGITS-1:0][3:0] stage_data;
  logic [DIGITS-1:0]      stage_dp;
  logic [DIGITS-1:0]      stage_blank;
  logic                   pending;

  logic [DIGITS-1:0][3:0] disp_data;
  logic [DIGITS-1:0]      disp_dp;
  logic [DIGITS-1:0]      disp_blank;

  logic [DIGITS-1:0] lz_mask;
  logic              zero_above;
  logic [DIGITS-1:0] digit_onehot;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blank;
  logic [7:0]        glyph_seg;

  assign slot_end = (slot_cnt == SLOT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);
  assign in_guard = (slot_cnt < GUARD);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Display only changes at the frame boundary, so a frame never mixes old and new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_data  <= '0;
      stage_dp    <= '0;
      stage_blank <= '0;
      pending     <= 1'b0;
      disp_data   <= '0;
      disp_dp     <= '0;
      disp_blank  <= '0;
    end else begin
      if (wrap && pending) begin
        disp_data  <= stage_data;
        disp_dp    <= stage_dp;
        disp_blank <= stage_blank;
      end
      if (load) begin
        stage_data  <= data_in;
        stage_dp    <= dp_in;
        stage_blank <= blank_in;
        pending     <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  // Walk down from the most significant digit; digit 0 is never suppressed.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above && (disp_data[k] == 4'd0);
      lz_mask[k] = zero_above && (LZ_BLANK != 0);
    end
  end

  always_comb begin
    digit_onehot = '0;
    cur_nib      = 4'd0;
    cur_dp       = 1'b0;
    cur_blank    = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        digit_onehot[k] = 1'b1;
        cur_nib         = disp_data[k];
        cur_dp          = disp_dp[k];
        cur_blank       = disp_blank[k] | lz_mask[k];
      end
    end
  end

  seg7_glyph u_glyph (
    .nibble   (cur_nib),
    .hex_mode (HEX_MODE != 0),
    .blank    (cur_blank),
    .dp       (cur_dp),
    .seg      (glyph_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= '1;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (in_guard) begin
        sel <= '1;
        seg <= SEG_BLANK;
      end else begin
        sel <= ~digit_onehot;
        seg <= glyph_seg;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: hex/no-LZ, decimal/LZ and single-digit instances share one stimulus.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;

  logic [3:0] sel_a, sel_b;
  logic [7:0] seg_a, seg_b, seg_c;
  logic [0:0] sel_c;
  logic       fd_a, fd_b, fd_c;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(4), .SLOT_CYC(8), .GUARD_CYC(2), .HEX_MODE(1), .LZ_BLANK(0)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .sel(sel_a), .seg(seg_a), .frame_done(fd_a));

  seg7_scan_driver #(.DIGITS(4), .SLOT_CYC(8), .GUARD_CYC(2), .HEX_MODE(0), .LZ_BLANK(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .sel(sel_b), .seg(seg_b), .frame_done(fd_b));

  seg7_scan_driver #(.DIGITS(1), .SLOT_CYC(4), .GUARD_CYC(1), .HEX_MODE(1), .LZ_BLANK(0)) dut_c (
    .clk(clk), .rst(rst), .data_in(data_in[3:0]), .dp_in(dp_in[0]), .blank_in(blank_in[0]),
    .load(load), .sel(sel_c), .seg(seg_c), .frame_done(fd_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_sel(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (sel_a !== target && n < 100) begin
      tick();
      n++;
    end
    check({tag, " sel"}, {4'h0, sel_a}, {4'h0, target});
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    while (fd_a !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, " frame_done"}, {7'd0, fd_a}, 8'd1);
  endtask

  // Waits for the next frame boundary, then checks digits 0..3 of the new frame.
  task automatic frame_check(input string tag, input logic [31:0] exp_a, input logic [31:0] exp_b);
    logic [3:0] t;
    wait_frame(tag);
    for (int k = 0; k < 4; k++) begin
      t = 4'b1111;
      t[k] = 1'b0;
      wait_sel(t, $sformatf("%s d%0d", tag, k));
      check($sformatf("%s a seg d%0d", tag, k), seg_a, exp_a[8*k +: 8]);
      check($sformatf("%s b seg d%0d", tag, k), seg_b, exp_b[8*k +: 8]);
      check($sformatf("%s b sel d%0d", tag, k), {4'h0, sel_b}, {4'h0, t});
    end
  endtask

  task automatic load_value(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    data_in  = d;
    dp_in    = dp;
    blank_in = bl;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; data_in = '0; dp_in = '0; blank_in = '0; load = 1'b0;
    repeat (3) tick();
    check("reset sel", {4'h0, sel_a}, 8'h0F);
    check("reset seg", seg_a, 8'hFF);
    check("reset frame_done", {7'd0, fd_a}, 8'd0);

    // Release: 3 guard samples, 6 on digit 0, 2 guard, then digit 1.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("startup guard %0d", i), {4'h0, sel_a}, 8'h0F);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      check($sformatf("startup d0 sel %0d", i), {4'h0, sel_a}, 8'h0E);
      check($sformatf("startup d0 seg %0d", i), seg_a, 8'h03);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("slot guard %0d", i), {4'h0, sel_a}, 8'h0F);
      check($sformatf("slot guard seg %0d", i), seg_a, 8'hFF);
      tick();
    end
    check("startup d1 sel", {4'h0, sel_a}, 8'h0D);
    check("startup d1 seg a", seg_a, 8'h03);
    check("startup d1 seg b lz", seg_b, 8'hFF);

    wait_frame("period start");
    n = 0;
    do begin tick(); n++; end while (fd_a !== 1'b1 && n < 100);
    check("frame period", 8'(n), 8'd32);

    // Load mid-frame: digit 2 of the current frame still shows the old value.
    repeat (10) tick();
    load_value(16'h1234, 4'h0, 4'h0);
    wait_sel(4'b1011, "hold d2");
    check("hold d2 seg", seg_a, 8'h03);
    frame_check("ld1234", {8'h9F, 8'h25, 8'h0D, 8'h99}, {8'h9F, 8'h25, 8'h0D, 8'h99});

    n = 0;
    while (sel_c !== 1'b0 && n < 20) begin tick(); n++; end
    check("single digit seg", seg_c, 8'h99);
    n = 0;
    while (fd_c !== 1'b1 && n < 20) begin tick(); n++; end
    check("single digit wrap seen", {7'd0, fd_c}, 8'd1);
    n = 0;
    do begin tick(); n++; end while (fd_c !== 1'b1 && n < 20);
    check("single digit period", 8'(n), 8'd4);

    // Two loads in one frame: last write wins.
    wait_sel(4'b1110, "two sync");
    load_value(16'h1111, 4'h0, 4'h0);
    load_value(16'h00AF, 4'h0, 4'h0);
    wait_sel(4'b1101, "two hold");
    check("two hold seg", seg_a, 8'h0D);
    frame_check("two", {8'h03, 8'h03, 8'h11, 8'h71}, {8'hFF, 8'hFF, 8'hFF, 8'hFF});

    load_value(16'h0050, 4'h0, 4'h0);
    frame_check("lz50", {8'h03, 8'h03, 8'h49, 8'h03}, {8'hFF, 8'hFF, 8'h49, 8'h03});
    load_value(16'h0000, 4'h0, 4'h0);
    frame_check("lz0", {8'h03, 8'h03, 8'h03, 8'h03}, {8'hFF, 8'hFF, 8'hFF, 8'h03});

    load_value(16'h1234, 4'b0100, 4'b0100);
    frame_check("dpblk", {8'h9F, 8'hFE, 8'h0D, 8'h99}, {8'h9F, 8'hFE, 8'h0D, 8'h99});

    // Reset during digit 2 with a pending load: restart at guard, pending dropped.
    wait_sel(4'b1011, "rst sync");
    load_value(16'h8888, 4'h0, 4'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst sel", {4'h0, sel_a}, 8'h0F);
    check("rst seg", seg_a, 8'hFF);
    check("rst frame_done", {7'd0, fd_a}, 8'd0);
    tick();
    check("rst guard 1", {4'h0, sel_a}, 8'h0F);
    tick();
    check("rst guard 2", {4'h0, sel_a}, 8'h0F);
    tick();
    check("rst d0 sel", {4'h0, sel_a}, 8'h0E);
    check("rst d0 seg a", seg_a, 8'h03);
    check("rst d0 seg b", seg_b, 8'h03);
    frame_check("rst", {8'h03, 8'h03, 8'h03, 8'h03}, {8'hFF, 8'hFF, 8'hFF, 8'h03});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
